ant_group_buffer: RTL and testbench
===================================

Name: ant_group_buffer

Overview:
- Generalised antenna-alignment buffer for the PUSCH dimension-reduction front end.
- Accepts NGRP antenna groups arriving serially (one block of RE_NUM beats per group, each beat ANT lanes of 32-bit IQ) and ping-pong buffers them in two frame banks.
- Once all NGRP groups of a frame are written, it streams the frame out with all groups aligned side by side, one RE per beat, feeding the beamforming/dim-reduce stage.
- Adds runtime RE count, overflow drop/flag, frame tlast and a readable-bank status over the two-antenna predecessor.

Parameters:
- ANT, 4, 32-bit IQ lanes per beat per group
- NGRP, 4, antenna groups per frame (>=2)
- ADDR_WIDTH, 11, RE address width
- RE_MAX, 1584, RAM depth per group per bank (132*12)
- READ_LATENCY, 3, RAM read latency in cycles (>=1)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_re_num  in  ADDR_WIDTH  REs per group block, 1..RE_MAX; sampled at frame start
- i_iq_addr  in  ADDR_WIDTH  RE write address within block
- i_iq_data  in  ANT*32  IQ beat
- i_iq_vld  in  1  beat valid
- i_iq_last  in  1  last beat of current group block
- o_ant_data  out  NGRP*ANT*32  aligned output; group g at bits [g*ANT*32 +: ANT*32]
- o_ant_addr  out  ADDR_WIDTH  RE index of o_ant_data
- o_tvalid  out  1  output valid
- o_tlast  out  1  last RE of frame
- o_overflow  out  1  one-cycle pulse when a frame is dropped
- o_bank_full  out  2  per-bank "frame complete, awaiting read" flags

Behaviour:
- Reset: all outputs 0; group counter 0; write bank 0; both banks empty; read FSM in IDLE; in-flight read pipeline flushed (o_tvalid 0 next cycle).
- Storage: one RAM, 2*NGRP*RE_MAX words of ANT*32 bits; word address = {bank, group, addr}.
- Write side, one-cycle input register:
  - Group counter increments on each i_iq_vld & i_iq_last and wraps NGRP-1 -> 0.
  - At wrap, the written bank's full flag is set and the write bank toggles.
  - Frame start is the first vld beat with group==0. If the target bank's full flag is set there, the whole frame (NGRP lasts) is discarded; the group counter still advances; o_overflow pulses once at that first beat.
  - i_iq_addr >= RE_MAX: write suppressed; the beat is still counted for last.
- Read FSM:
  - IDLE: when the full flag of the read bank (starts 0, toggles per frame) is set, latch that frame's RE count and go to READ.
  - READ: issue NGRP parallel reads per cycle (one per group, same RE index), index 0..re_num-1, one per cycle, no gaps. After the final index, clear the full flag and toggle the read bank in the same cycle, then go to IDLE.
  - IDLE->READ takes at least one cycle, so consecutive frames are separated by a bubble of at least 1 cycle.
- Latency: o_tvalid/o_ant_data/o_ant_addr appear READ_LATENCY+1 cycles after the read issue. o_tlast is asserted with the beat whose o_ant_addr == re_num-1.
- Simultaneous events:
  - Full-flag set by write and clear by read on different banks in the same cycle: both take effect.
  - Same bank: the clear applies first, so a writer starting that cycle sees the bank as free on the next cycle, not this one.
- Write and read on the same bank never overlap: the full flag gates writes.
- Mid-frame reset: partial data is abandoned; no output is emitted for it.

Test Plan:
- Nominal: NGRP=4, ANT=4, re_num=8; write 4 groups with data = {g, addr}. Required: 8 beats with o_tvalid, addr 0..7; lane g holds {g, addr}; o_tlast on addr 7; first beat 1+READ_LATENCY+1 cycles after bank 0 becomes full.
- Ping-pong back-to-back: two frames written with no gaps. Required: bank 0 read overlaps bank 1 write; outputs in frame order; ≥1-cycle gap between frames; o_overflow stays 0.
- Overflow: stall reads by writing 3 frames faster than the output can drain (re_num=1584). Required: 3rd frame dropped, one o_overflow pulse at its first beat, o_bank_full=2'b11; after drain, the 4th frame is output correctly.
- Runtime length: frame A with re_num=12, then frame B with re_num=1584. Required: A outputs exactly 12 beats, B outputs 1584 beats, each with tlast on the final beat.
- Out-of-range address: i_iq_addr=2000 on one beat. Required: no RAM corruption, group count still correct.
- Reset mid-read: assert i_reset at RE 5 of a readout. Required: o_tvalid 0 from the next cycle, o_bank_full=0; a fresh frame afterwards is output correctly.

Source files
------------

// File: rtl/ant_group_buffer.sv
// Ping-pong frame buffer: NGRP antenna groups arrive serially and leave
// side by side, one RE per beat, for the PUSCH dimension-reduction stage.
module ant_group_buffer #(
    parameter int ANT          = 4,
    parameter int NGRP         = 4,
    parameter int ADDR_WIDTH   = 11,
    parameter int RE_MAX       = 1584,
    parameter int READ_LATENCY = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [ADDR_WIDTH-1:0]  i_re_num,
    input  logic [ADDR_WIDTH-1:0]  i_iq_addr,
    input  logic [ANT*32-1:0]      i_iq_data,
    input  logic                   i_iq_vld,
    input  logic                   i_iq_last,
    output logic [NGRP*ANT*32-1:0] o_ant_data,
    output logic [ADDR_WIDTH-1:0]  o_ant_addr,
    output logic                   o_tvalid,
    output logic                   o_tlast,
    output logic                   o_overflow,
    output logic [1:0]             o_bank_full
);
    localparam int W     = ANT * 32;
    localparam int GW    = $clog2(NGRP);
    localparam int DEPTH = 2 * NGRP * RE_MAX;
    localparam int MW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] RE_LIMIT = (ADDR_WIDTH + 1)'(RE_MAX);
    localparam logic [GW-1:0]       GRP_LAST = GW'(NGRP - 1);

    typedef enum logic {IDLE, READ} rd_state_t;

    logic [W-1:0] mem [DEPTH];

    function automatic logic [MW-1:0] mem_ptr(input logic bank, input logic [GW-1:0] grp,
                                              input logic [ADDR_WIDTH-1:0] addr);
        return MW'((32'(bank) * NGRP + 32'(grp)) * RE_MAX + 32'(addr));
    endfunction

    logic                  in_vld, in_last;
    logic [ADDR_WIDTH-1:0] in_addr, in_re_num;
    logic [W-1:0]          in_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            in_vld  <= 1'b0;
            in_last <= 1'b0;
        end else begin
            in_vld  <= i_iq_vld;
            in_last <= i_iq_last;
        end
        in_addr   <= i_iq_addr;
        in_re_num <= i_re_num;
        in_data   <= i_iq_data;
    end

    logic [GW-1:0]         grp;
    logic                  wr_bank, in_frame, dropping;
    logic [1:0]            full, full_nxt;
    logic [ADDR_WIDTH-1:0] bank_re_num [2];
    logic                  frame_start, drop_now, wr_en, grp_wrap, set_full;

    rd_state_t             state;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_idx, rd_num;
    logic                  rd_issue, rd_final;

    // The drop decision is frozen at the frame's first beat and held until the wrap.
    assign frame_start = in_vld && (grp == '0) && !in_frame;
    assign drop_now    = frame_start ? full[wr_bank] : dropping;
    assign wr_en       = in_vld && !drop_now && ({1'b0, in_addr} < RE_LIMIT);
    assign grp_wrap    = in_vld && in_last && (grp == GRP_LAST);
    assign set_full    = grp_wrap && !drop_now;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            grp        <= '0;
            wr_bank    <= 1'b0;
            in_frame   <= 1'b0;
            dropping   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= frame_start && full[wr_bank];
            if (frame_start) begin
                in_frame <= 1'b1;
                dropping <= full[wr_bank];
            end
            if (in_vld && in_last) begin
                grp <= (grp == GRP_LAST) ? '0 : grp + GW'(1);
                if (grp_wrap) begin
                    in_frame <= 1'b0;
                    dropping <= 1'b0;
                    if (!drop_now)
                        wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (frame_start && !full[wr_bank])
            bank_re_num[wr_bank] <= in_re_num;
        if (wr_en)
            mem[mem_ptr(wr_bank, grp, in_addr)] <= in_data;
    end

    // Clear before set: a same-bank writer only sees the freed bank a cycle later.
    always_comb begin
        full_nxt = full;
        if (rd_final)
            full_nxt[rd_bank] = 1'b0;
        if (set_full)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            full <= '0;
        else
            full <= full_nxt;
    end

    assign o_bank_full = full;

    assign rd_issue = (state == READ);
    assign rd_final = rd_issue && (rd_idx == rd_num - ADDR_WIDTH'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            rd_num  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        rd_num <= bank_re_num[rd_bank];
                        rd_idx <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (rd_final) begin
                        rd_bank <= ~rd_bank;
                        state   <= IDLE;
                    end else begin
                        rd_idx <= rd_idx + ADDR_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NGRP*W-1:0]       pipe_data [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld, pipe_last;

    always_ff @(posedge i_clk) begin
        for (int unsigned g = 0; g < NGRP; g++)
            pipe_data[0][g*W +: W] <= mem[mem_ptr(rd_bank, GW'(g), rd_idx)];
        pipe_addr[0] <= rd_idx;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pipe_vld   <= '0;
            pipe_last  <= '0;
            o_tvalid   <= 1'b0;
            o_tlast    <= 1'b0;
            o_ant_data <= '0;
            o_ant_addr <= '0;
        end else begin
            pipe_vld[0]  <= rd_issue;
            pipe_last[0] <= rd_final;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            o_tvalid   <= pipe_vld[READ_LATENCY-1];
            o_tlast    <= pipe_vld[READ_LATENCY-1] & pipe_last[READ_LATENCY-1];
            o_ant_data <= pipe_data[READ_LATENCY-1];
            o_ant_addr <= pipe_addr[READ_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_ant_group_buffer.sv
// Bench for ant_group_buffer: a RAM-image model plus per-frame expected beat
// queues, compared against the captured output stream.
module tb_ant_group_buffer;
    localparam int ANT = 4, NGRP = 4, AW = 11, RE_MAX = 1584, RL = 3;
    localparam int W = ANT * 32, DW = NGRP * W;

    logic          clk = 1'b0, rst = 1'b1;
    logic [AW-1:0] i_re_num = '0, i_iq_addr = '0;
    logic [W-1:0]  i_iq_data = '0;
    logic          i_iq_vld = 1'b0, i_iq_last = 1'b0;
    logic [DW-1:0] o_ant_data;
    logic [AW-1:0] o_ant_addr;
    logic          o_tvalid, o_tlast, o_overflow;
    logic [1:0]    o_bank_full;

    ant_group_buffer #(.ANT(ANT), .NGRP(NGRP), .ADDR_WIDTH(AW), .RE_MAX(RE_MAX),
                       .READ_LATENCY(RL)) dut (
        .i_clk(clk), .i_reset(rst), .i_re_num(i_re_num), .i_iq_addr(i_iq_addr),
        .i_iq_data(i_iq_data), .i_iq_vld(i_iq_vld), .i_iq_last(i_iq_last),
        .o_ant_data(o_ant_data), .o_ant_addr(o_ant_addr), .o_tvalid(o_tvalid),
        .o_tlast(o_tlast), .o_overflow(o_overflow), .o_bank_full(o_bank_full));

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Model of RAM contents; addresses never written are left unchecked
    logic [W-1:0] mmem   [2][NGRP][RE_MAX];
    bit           mknown [2][NGRP][RE_MAX];
    bit           m_wbank = 1'b0;

    int            exp_addr[$], obs_addr[$], obs_cyc[$];
    bit            exp_last[$], obs_last[$];
    logic [DW-1:0] exp_data[$], exp_mask[$], obs_data[$];
    int            ovf_cnt = 0, full0_rise = -1;
    bit            prev_full0 = 1'b0;

    always @(negedge clk) begin
        if (o_tvalid === 1'b1) begin
            obs_addr.push_back(int'(o_ant_addr));
            obs_data.push_back(o_ant_data);
            obs_last.push_back(o_tlast === 1'b1);
            obs_cyc.push_back(cyc);
        end
        if (o_overflow === 1'b1) ovf_cnt++;
        if (o_bank_full[0] === 1'b1 && !prev_full0) full0_rise = cyc;
        prev_full0 = (o_bank_full[0] === 1'b1);
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int l = 0; l < ANT; l++) r[l*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_queues();
        exp_addr.delete(); exp_last.delete(); exp_data.delete(); exp_mask.delete();
        obs_addr.delete(); obs_last.delete(); obs_data.delete(); obs_cyc.delete();
        ovf_cnt = 0;
    endtask

    task automatic drive_beat(input int re_num, input int addr, input logic [W-1:0] d, input bit last);
        @(posedge clk); #1;
        i_re_num = AW'(re_num); i_iq_addr = AW'(addr); i_iq_data = d;
        i_iq_vld = 1'b1; i_iq_last = last;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        i_iq_vld = 1'b0; i_iq_last = 1'b0;
    endtask

    // oor_grp >= 0 appends an out-of-range beat (addr 2000) as that group's last beat
    task automatic send_frame(input int re_num, input int beats, input bit dropped,
                              input bit pattern, input int oor_grp);
        logic [W-1:0] d, m;
        logic [DW-1:0] ed, em;
        for (int g = 0; g < NGRP; g++) begin
            for (int a = 0; a < beats; a++) begin
                if (pattern) for (int l = 0; l < ANT; l++) d[l*32 +: 32] = {16'(g), 16'(a)};
                else d = rand_word();
                drive_beat(re_num, a, d, (a == beats - 1) && (g != oor_grp));
                if (!dropped) begin
                    mmem[m_wbank][g][a] = d;
                    mknown[m_wbank][g][a] = 1'b1;
                end
            end
            if (g == oor_grp) drive_beat(re_num, 2000, rand_word(), 1'b1);
        end
        if (!dropped) begin
            for (int r = 0; r < re_num; r++) begin
                ed = '0; em = '0;
                for (int g = 0; g < NGRP; g++)
                    if (mknown[m_wbank][g][r]) begin
                        m = '1;
                        ed[g*W +: W] = mmem[m_wbank][g][r];
                        em[g*W +: W] = m;
                    end
                exp_addr.push_back(r); exp_last.push_back(r == re_num - 1);
                exp_data.push_back(ed); exp_mask.push_back(em);
            end
            m_wbank = ~m_wbank;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int c = 0;
        while (obs_addr.size() < n && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        ok = (obs_addr.size() >= n);
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if ({o_tvalid, o_tlast, o_overflow, o_bank_full} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b, required 00000", {o_tvalid, o_tlast, o_overflow, o_bank_full});
        end
        compared++;
        if (o_ant_data !== '0 || o_ant_addr !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got addr %h data %h, required 0", o_ant_addr, o_ant_data);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        compared++;
        if (o_tvalid !== 1'b0 || o_bank_full !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_idle: got tvalid %b full %b, required 0 00", o_tvalid, o_bank_full);
        end
        m_wbank = 1'b0;
    endtask

    task automatic test_nominal();
        bit ok;
        clear_queues();
        full0_rise = -1;
        send_frame(8, 8, 1'b0, 1'b1, -1);
        go_idle();
        wait_beats(8, 200, ok);
        compared++;
        if (!ok || obs_addr.size() != 8) begin
            mismatched++;
            $display("FAIL nominal_count: got %0d beats, required 8", obs_addr.size());
        end
        for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL nominal_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
        compared++;
        if (obs_cyc.size() == 0 || obs_cyc[0] - full0_rise != RL + 2) begin
            mismatched++;
            $display("FAIL nominal_latency: got %0d cycles, required %0d",
                     (obs_cyc.size() == 0) ? -1 : obs_cyc[0] - full0_rise, RL + 2);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int re1, re2, end_cyc, n;
        clear_queues();
        re1 = $urandom_range(4, 12);
        re2 = $urandom_range(4, 12);
        n = re1 + re2;
        send_frame(re1, re1, 1'b0, 1'b0, -1);
        send_frame(re2, re2, 1'b0, 1'b0, -1);
        end_cyc = cyc;
        go_idle();
        wait_beats(n, 300, ok);
        compared++;
        if (!ok || obs_addr.size() != n) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d beats, required %0d", obs_addr.size(), n);
        end
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL b2b_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
        if (obs_cyc.size() >= n) begin
            compared++;
            if (!(obs_cyc[0] < end_cyc)) begin
                mismatched++;
                $display("FAIL b2b_overlap: got first out cycle %0d, required before %0d", obs_cyc[0], end_cyc);
            end
            compared++;
            if (obs_cyc[re1] - obs_cyc[re1-1] < 2) begin
                mismatched++;
                $display("FAIL b2b_gap: got spacing %0d, required >= 2", obs_cyc[re1] - obs_cyc[re1-1]);
            end
        end
        compared++;
        if (ovf_cnt != 0) begin
            mismatched++;
            $display("FAIL b2b_overflow: got %0d pulses, required 0", ovf_cnt);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int n;
        clear_queues();
        send_frame(RE_MAX, 1, 1'b0, 1'b0, -1);
        send_frame(RE_MAX, 1, 1'b0, 1'b0, -1);
        send_frame(RE_MAX, 1, 1'b1, 1'b0, -1);
        go_idle();
        repeat (2) @(posedge clk);
        #2;
        compared++;
        if (o_bank_full !== 2'b11) begin
            mismatched++;
            $display("FAIL ovf_bank_full: got %b, required 11", o_bank_full);
        end
        compared++;
        if (ovf_cnt != 1) begin
            mismatched++;
            $display("FAIL ovf_pulse: got %0d pulses, required 1", ovf_cnt);
        end
        n = 2 * RE_MAX;
        wait_beats(n, 5000, ok);
        compared++;
        if (!ok || obs_addr.size() != n) begin
            mismatched++;
            $display("FAIL ovf_drain_count: got %0d beats, required %0d", obs_addr.size(), n);
        end
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL ovf_drain_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
        compared++;
        if (ovf_cnt != 1) begin
            mismatched++;
            $display("FAIL ovf_pulse_total: got %0d pulses, required 1", ovf_cnt);
        end
        clear_queues();
        send_frame(8, 8, 1'b0, 1'b0, -1);
        go_idle();
        wait_beats(8, 200, ok);
        compared++;
        if (!ok || obs_addr.size() != 8) begin
            mismatched++;
            $display("FAIL ovf_after_count: got %0d beats, required 8", obs_addr.size());
        end
        for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL ovf_after_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_runtime_length();
        bit ok;
        int n, lasts;
        clear_queues();
        n = 12 + RE_MAX;
        send_frame(12, 12, 1'b0, 1'b0, -1);
        send_frame(RE_MAX, RE_MAX, 1'b0, 1'b0, -1);
        go_idle();
        wait_beats(n, 9000, ok);
        compared++;
        if (!ok || obs_addr.size() != n) begin
            mismatched++;
            $display("FAIL runtime_count: got %0d beats, required %0d", obs_addr.size(), n);
        end
        lasts = 0;
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            lasts += int'(obs_last[i]);
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL runtime_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
        compared++;
        if (lasts != 2) begin
            mismatched++;
            $display("FAIL runtime_tlast_count: got %0d, required 2", lasts);
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int n;
        clear_queues();
        n = 3 * 420;
        send_frame(420, 420, 1'b0, 1'b0, -1);
        send_frame(420, 420, 1'b0, 1'b0, NGRP - 1);
        send_frame(420, 8, 1'b0, 1'b0, -1);
        go_idle();
        wait_beats(n, 6000, ok);
        compared++;
        if (!ok || obs_addr.size() != n) begin
            mismatched++;
            $display("FAIL oor_count: got %0d beats, required %0d", obs_addr.size(), n);
        end
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL oor_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int c, n_before;
        clear_queues();
        send_frame(16, 16, 1'b0, 1'b0, -1);
        go_idle();
        c = 0;
        while (obs_addr.size() < 6 && c < 500) begin
            @(posedge clk); #2;
            c++;
        end
        compared++;
        if (obs_addr.size() < 6 || obs_addr[5] != 5) begin
            mismatched++;
            $display("FAIL rst_mid_reach: got %0d beats, required RE 5 observed", obs_addr.size());
        end
        rst = 1'b1;
        @(posedge clk); #2;
        compared++;
        if (o_tvalid !== 1'b0 || o_bank_full !== 2'b00) begin
            mismatched++;
            $display("FAIL rst_mid_state: got tvalid %b full %b, required 0 00", o_tvalid, o_bank_full);
        end
        rst = 1'b0;
        n_before = obs_addr.size();
        repeat (30) @(posedge clk);
        #2;
        compared++;
        if (obs_addr.size() != n_before) begin
            mismatched++;
            $display("FAIL rst_mid_abandon: got %0d extra beats, required 0", obs_addr.size() - n_before);
        end
        m_wbank = 1'b0;
        clear_queues();
        send_frame(10, 10, 1'b0, 1'b0, -1);
        go_idle();
        wait_beats(10, 200, ok);
        compared++;
        if (!ok || obs_addr.size() != 10) begin
            mismatched++;
            $display("FAIL rst_fresh_count: got %0d beats, required 10", obs_addr.size());
        end
        for (int i = 0; i < 10 && i < obs_addr.size(); i++) begin
            compared++;
            if (obs_addr[i] !== exp_addr[i] || obs_last[i] !== exp_last[i] ||
                (obs_data[i] & exp_mask[i]) !== (exp_data[i] & exp_mask[i])) begin
                mismatched++;
                $display("FAIL rst_fresh_beat%0d: got addr %0d last %0b data %h, required addr %0d last %0b data %h",
                         i, obs_addr[i], obs_last[i], obs_data[i] & exp_mask[i], exp_addr[i], exp_last[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_overflow();
        test_runtime_length();
        test_out_of_range();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
